adder_share_ctrl: RTL and testbench

- Round-robin arbiter and sequencer that shares one internal ripple-carry adder among N_REQ requesters.
- The adder is a slow combinational path, so the controller holds the operands in registers for ADD_CYCLES cycles (multicycle path) before capturing the result.
- It returns the result with the requester ID over a valid/ready response channel.
- Sits between the ALU-side clients and the shared 64-bit ripple-carry adder datapath.

---
 rtl/adder_share_ctrl.sv | 151 +++++++++++++++
 tb/tb_adder_share_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: round-robin sharing of one ripple-carry adder among N_REQ requesters.
// Latency: accept edge + ADD_CYCLES edges to rsp_valid; one op per ADD_CYCLES+2 cycles at best.
// Backpressure: rsp_* held while rsp_ready=0; no grants until the response is taken.
// Optional: define ADDER_SHARE_OVF_EN to add the rsp_ovf signed-overflow output.
module adder_share_ctrl #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 64,
  parameter int ADD_CYCLES = 2,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_sub,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout
`ifdef ADDER_SHARE_OVF_EN
  ,
  output logic                   rsp_ovf
`endif
);

  localparam int CW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, win, id_q;
  logic             found;
  logic [N_REQ-1:0] upper, masked, pick_vec, grant;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
`ifdef ADDER_SHARE_OVF_EN
  logic             c_msb;
`endif

  // Rotating priority: prefer the lowest valid lane at or above rr_ptr, else wrap to the lowest valid lane.
  always_comb begin
    upper    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper[i] = (i >= int'(rr_ptr));
    end
    masked   = req_valid & upper;
    pick_vec = (masked != '0) ? masked : req_valid;
    found    = (req_valid != '0);
    win      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) win = IDW'(i);
    end
    grant    = found ? (N_REQ'(1) << win) : '0;
  end

  // Ripple-carry adder fed only by the held operand registers (multicycle path).
  always_comb begin
    logic c;
    c       = op_cin;
    add_sum = '0;
`ifdef ADDER_SHARE_OVF_EN
    c_msb   = 1'b0;
`endif
    for (int i = 0; i < WIDTH; i++) begin
`ifdef ADDER_SHARE_OVF_EN
      if (i == WIDTH - 1) c_msb = c;
`endif
      add_sum[i] = op_a[i] ^ op_b[i] ^ c;
      c          = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
    end
    add_cout = c;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found)          state_nxt = COMPUTE;
      COMPUTE: if (cnt == '0)      state_nxt = RESP;
      RESP:    if (rsp_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Grant output: only in IDLE, one-hot by construction of grant.
  always_comb begin
    req_ready = (state == IDLE) ? grant : '0;
  end

  // Operand capture, wait counter, pointer rotation and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            op_a   <= req_a[win*WIDTH +: WIDTH];
            op_b   <= req_sub[win] ? ~req_b[win*WIDTH +: WIDTH] : req_b[win*WIDTH +: WIDTH];
            op_cin <= req_sub[win];
            id_q   <= win;
            rr_ptr <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
            cnt    <= CW'(ADD_CYCLES - 1);
          end
        end
        COMPUTE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
`ifdef ADDER_SHARE_OVF_EN
            rsp_ovf   <= c_msb ^ add_cout;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: random and directed ops, per-lane expected-result queues,
// a negedge monitor with an arbitration model checking grants, latency, hold and results.
module tb_adder_share_ctrl;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int AC = 2;
  localparam int IW = $clog2(N);

  typedef struct { logic sub; logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct { logic [W-1:0] sum; logic cout; logic ovf; } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, req_sub;
  logic [N*W-1:0]   req_a, req_b;
  logic             rsp_valid, rsp_ready, rsp_cout;
  logic [IW-1:0]    rsp_id;
  logic [W-1:0]     rsp_sum;
`ifdef ADDER_SHARE_OVF_EN
  logic             rsp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  op_t  pend [N][$];
  res_t expq [N][$];
  int   grant_log [$];
  bit   mon_busy = 0;

  adder_share_ctrl #(.N_REQ(N), .WIDTH(W), .ADD_CYCLES(AC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef ADDER_SHARE_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain wide addition / subtraction on the requester's operands.
  function automatic res_t ref_model(input op_t o);
    res_t r;
    logic [W:0]   full;
    logic [W-1:0] bb;
    bb     = o.sub ? ~o.b : o.b;
    full   = {1'b0, o.a} + {1'b0, bb} + {{W{1'b0}}, o.sub};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (o.a[W-1] == bb[W-1]) && (full[W-1] != o.a[W-1]);
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic issue(input int lane, input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    op_t o;
    o.sub = sub; o.a = a; o.b = b;
    pend[lane].push_back(o);
    expq[lane].push_back(ref_model(o));
  endtask

  // Requester driver: present the head of each lane's queue, retire it once accepted.
  initial begin
    logic [N-1:0] acc;
    req_valid = '0; req_sub = '0; req_a = '0; req_b = '0;
    forever begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        if (pend[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_sub[i]           = pend[i][0].sub;
          req_a[i*W +: W]      = pend[i][0].a;
          req_b[i*W +: W]      = pend[i][0].b;
        end else begin
          req_valid[i]         = 1'b0;
        end
      end
    end
  end

  // Monitor: arbitration model, latency, response hold and result scoreboard.
  initial begin
    int mptr, cur_id, lat, w;
    bit first, prev_v, prev_r;
    logic [W-1:0] prev_sum;
    logic [IW-1:0] prev_id;
    logic prev_cout;
    logic [N-1:0] eg;
    res_t e;
    mptr = 0; cur_id = 0; lat = 0; first = 0; prev_v = 0; prev_r = 0;
    prev_sum = '0; prev_id = '0; prev_cout = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mptr = 0; mon_busy = 0; prev_v = 0; first = 0;
      end else begin
        w  = mon_busy ? -1 : pick(req_valid, mptr);
        eg = (w < 0) ? '0 : (N'(1) << w);
        if (mon_busy || req_valid != '0) chk("grant", W'(req_ready), W'(eg));
        if (w >= 0 && req_ready == eg) begin
          mon_busy = 1; mptr = (w + 1) % N; cur_id = w; lat = 0; first = 1;
          grant_log.push_back(w);
        end else if (mon_busy) begin
          lat++;
          if (rsp_valid && first) begin
            first = 0;
            chk("latency_edges", W'(lat - 1), W'(AC));
          end
        end
        if (rsp_valid && !mon_busy) chk("unexpected_rsp", W'(rsp_valid), '0);
        if (prev_v && !prev_r) begin
          chk("hold_valid", W'(rsp_valid), W'(1));
          chk("hold_sum", rsp_sum, prev_sum);
          chk("hold_id_cout", W'({rsp_id, rsp_cout}), W'({prev_id, prev_cout}));
        end
        if (rsp_valid && rsp_ready && mon_busy) begin
          chk("rsp_id", W'(rsp_id), W'(cur_id));
          if (expq[int'(rsp_id)].size() == 0) begin
            chk("rsp_no_expected", W'(rsp_valid), '0);
          end else begin
            e = expq[int'(rsp_id)].pop_front();
            chk("rsp_sum", rsp_sum, e.sum);
            chk("rsp_cout", W'(rsp_cout), W'(e.cout));
`ifdef ADDER_SHARE_OVF_EN
            chk("rsp_ovf", W'(rsp_ovf), W'(e.ovf));
`endif
          end
          mon_busy = 0;
        end
        prev_v = rsp_valid; prev_r = rsp_ready;
        prev_sum = rsp_sum; prev_id = rsp_id; prev_cout = rsp_cout;
      end
    end
  end

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() != 0 || expq[i].size() != 0) return 0;
    end
    return 1;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(all_empty() && !mon_busy && !rsp_valid) && n < 3000);
    if (n >= 3000) chk("drain_timeout", W'(1), '0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, W'(req_ready), '0);
    chk({tag, "_rsp_valid"}, W'(rsp_valid), '0);
    chk({tag, "_rsp_id"},    W'(rsp_id), '0);
    chk({tag, "_rsp_sum"},   rsp_sum, '0);
    chk({tag, "_rsp_cout"},  W'(rsp_cout), '0);
  endtask

  // Stimulus sequence.
  initial begin
    logic [W-1:0] ones;
    int n;
    ones = '1;
    rst_n = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);

    issue(0, 1'b0, 64'd5, 64'd7);              drain();
    chk("add_5_7_sum", rsp_sum, 64'd12);
    issue(0, 1'b0, ones, 64'd1);               drain();
    chk("wrap_sum", rsp_sum, '0);
    chk("wrap_cout", W'(rsp_cout), W'(1));
    issue(2, 1'b1, 64'd3, 64'd5);              drain();
    chk("sub_3_5_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_3_5_cout", W'(rsp_cout), '0);
    issue(2, 1'b1, 64'd5, 64'd3);              drain();
    chk("sub_5_3_sum", rsp_sum, 64'd2);
    chk("sub_5_3_cout", W'(rsp_cout), W'(1));

    // Round robin from reset.
    reset_pulse();
    grant_log.delete();
    issue(0, 1'b0, 64'd10, 64'd1);
    issue(1, 1'b0, 64'd20, 64'd2);
    issue(3, 1'b1, 64'd30, 64'd3);
    drain();
    chk("rr1_count", W'(grant_log.size()), W'(3));
    if (grant_log.size() == 3) begin
      chk("rr1_g0", W'(grant_log[0]), W'(0));
      chk("rr1_g1", W'(grant_log[1]), W'(1));
      chk("rr1_g2", W'(grant_log[2]), W'(3));
    end
    grant_log.delete();
    for (int i = 0; i < N; i++) issue(i, 1'(i & 1), W'($urandom), W'($urandom));
    drain();
    chk("rr2_count", W'(grant_log.size()), W'(N));
    if (grant_log.size() == N) begin
      for (int i = 0; i < N; i++) chk("rr2_order", W'(grant_log[i]), W'(i));
    end

    // Backpressure with requester 2 waiting.
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    issue(0, 1'b0, 64'h1234, 64'h4321);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_rsp_seen", W'(rsp_valid), W'(1));
    issue(2, 1'b1, 64'h100, 64'h1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_no_grant", W'(req_ready), '0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_no_grant", W'(req_ready), '0);
    @(negedge clk);
    chk("bp_grant2_next", W'(req_ready), W'(4'b0100));
    drain();

    // Reset one cycle after accept: operation abandoned, pointer back to 0.
    issue(1, 1'b0, 64'hAAAA, 64'h5555);
    n = 0;
    while (!req_ready[1] && n < 50) begin @(negedge clk); n++; end
    chk("rst_accept_seen", W'(req_ready[1]), W'(1));
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_zero_outputs("midreset");
    expq[1].delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_rsp_after_reset", W'(rsp_valid), '0);
    end
    grant_log.delete();
    issue(3, 1'b0, 64'd1, 64'd1);
    issue(1, 1'b0, 64'd2, 64'd2);
    drain();
    if (grant_log.size() == 2) chk("ptr_reset_first", W'(grant_log[0]), W'(1));
    else chk("ptr_reset_count", W'(grant_log.size()), W'(2));

`ifdef ADDER_SHARE_OVF_EN
    issue(0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1); drain();
    chk("ovf_add", W'(rsp_ovf), W'(1));
    issue(1, 1'b1, 64'h8000_0000_0000_0000, 64'd1); drain();
    chk("ovf_sub", W'(rsp_ovf), W'(1));
`endif

    // Random traffic with random response backpressure.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        int lane;
        logic [W-1:0] a, b;
        lane = $urandom_range(0, N - 1);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        case ($urandom_range(0, 5))
          0: a = '1;
          1: b = '0;
          2: a = {1'b0, {(W-1){1'b1}}};
          default: ;
        endcase
        if (pend[lane].size() < 2) issue(lane, 1'($urandom_range(0, 1)), a, b);
      end
      @(posedge clk); #1 rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
